// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI write-slave types and constants
//
// Holds the burst encoding, response codes, the write FSM state type and
// the WRAP burst-length legality helper shared by the address generator.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } wr_state_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// rtl/axi_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP
//
// Ports:
//   addr, size, len, burst : current beat address and burst attributes
//   next_addr              : byte address of the following beat
//   wrap_bad               : WRAP burst with a length other than 2/4/8/16 beats
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  wrap_bad
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ONE << size;
    incr      = addr + step;
    // wrap length is (len+1)*step, a power of two for legal WRAP lengths
    wrap_mask = (({{(ADDR_WIDTH-8){1'b0}}, len} + ONE) << size) - ONE;
    case (burst)
      FIXED:   next_addr = addr;
      // base and offset occupy disjoint bits, so OR equals the sum
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default: next_addr = incr;
    endcase
    wrap_bad = (burst == WRAP) && !wrap_len_ok(len);
  end

endmodule

// File: rtl/axi_slave_wr.sv
// rtl/axi_slave_wr.sv - AXI4 write slave converting bursts to single-beat memory writes
//
// One outstanding transaction. AW is captured in IDLE, W beats are written
// out in DATA (one mem_we pulse per beat, one cycle after the handshake),
// and the response is held in RESP until bready. All outputs are registered.
// Optional build macro: AXI_SLV_WRAP_EN enables WRAP bursts; without it WRAP
// is drained without writes and answered with SLVERR.
//
// Ports:
//   aclk, aresetn                          : clock, async active-low reset
//   aw* / awvalid / awready                : write address channel
//   wdata, wstrb, wlast / wvalid / wready  : write data channel
//   bid, bresp / bvalid / bready           : write response channel
//   mem_we, mem_addr, mem_wdata, mem_wstrb : single-beat memory write port
module axi_slave_wr
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH/8));

  wr_state_t             state, state_nxt;
  logic [ID_WIDTH-1:0]   id_q;
  logic [2:0]            size_q;
  logic [7:0]            len_q;
  burst_t                burst_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            beat_cnt;
  logic                  err;
  logic                  drop;

  logic aw_hs, w_hs, b_hs;
  logic last_beat, len_hit, burst_bad, setup_err;

  logic [ADDR_WIDTH-1:0] gen_addr, next_addr;
  logic [2:0]            gen_size;
  logic [7:0]            gen_len;
  burst_t                gen_burst;
  logic                  gen_wrap_bad;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign len_hit   = (beat_cnt == len_q);
  assign last_beat = wlast || len_hit;

  // In IDLE the generator looks at the incoming AW so its wrap-length flag
  // can qualify the burst; afterwards it steps the captured burst.
  always_comb begin
    if (state == IDLE) begin
      gen_addr  = awaddr;
      gen_size  = awsize;
      gen_len   = awlen;
      gen_burst = burst_t'(awburst);
    end else begin
      gen_addr  = cur_addr;
      gen_size  = size_q;
      gen_len   = len_q;
      gen_burst = burst_q;
    end
  end

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (gen_addr),
    .size      (gen_size),
    .len       (gen_len),
    .burst     (gen_burst),
    .next_addr (next_addr),
    .wrap_bad  (gen_wrap_bad)
  );

`ifdef AXI_SLV_WRAP_EN
  assign burst_bad = (awburst == 2'b11);
`else
  assign burst_bad = awburst[1];
`endif

  assign setup_err = burst_bad || (awsize > SIZE_MAX) || gen_wrap_bad;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (aw_hs) state_nxt = DATA;
      DATA:    if (w_hs && last_beat) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs follow the next state so they are registered yet
  // change in the cycle right after the event that moves the FSM.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= OKAY;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      id_q      <= '0;
      size_q    <= '0;
      len_q     <= '0;
      burst_q   <= FIXED;
      cur_addr  <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      drop      <= 1'b0;
    end else begin
      awready <= (state_nxt == IDLE);
      wready  <= (state_nxt == DATA);
      bvalid  <= (state_nxt == RESP);
      mem_we  <= 1'b0;
      if (aw_hs) begin
        id_q     <= awid;
        size_q   <= awsize;
        len_q    <= awlen;
        burst_q  <= burst_t'(awburst);
        cur_addr <= awaddr;
        beat_cnt <= '0;
        err      <= setup_err;
        drop     <= setup_err;
      end
      if (w_hs) begin
        mem_we    <= !drop;
        mem_addr  <= cur_addr;
        mem_wdata <= wdata;
        mem_wstrb <= wstrb;
        cur_addr  <= next_addr;
        beat_cnt  <= beat_cnt + 8'd1;
        if (last_beat) begin
          bid   <= id_q;
          bresp <= (err || (wlast != len_hit)) ? SLVERR : OKAY;
        end
      end
    end
  end

endmodule
